// File: rtl/burst_mem_responder.sv
// Burst memory responder: serves one read or write burst at a time against a local RAM.
// Optional RESP_ADDR_ECHO_EN adds rdAddr, the RAM address travelling with each read beat.
module burst_mem_responder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 5,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              reqWr,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [LEN_W-1:0]  reqLen,
  output logic              reqReady,
  input  logic [DATA_W-1:0] wrData,
  input  logic              wrValid,
  output logic              wrReady,
  output logic [DATA_W-1:0] rdData,
  output logic              rdValid,
  output logic              burstDone,
  output logic              errOob
`ifdef RESP_ADDR_ECHO_EN
  ,
  output logic [ADDR_W-1:0] rdAddr
`endif
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DRAIN, WR, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [LEN_W-1:0]  cnt_reg, cnt_next;
  logic              err_reg, err_next;
  logic              rd_issue;
  logic              wr_fire;
  logic              last_beat;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              stage_valid [RD_LAT];
  logic              stage_last  [RD_LAT];
  logic [DATA_W-1:0] stage_data  [RD_LAT];
`ifdef RESP_ADDR_ECHO_EN
  logic [ADDR_W-1:0] stage_addr  [RD_LAT];
`endif

  assign last_beat = (cnt_reg == (len_reg - LEN_W'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    rd_issue   = 1'b0;
    wr_fire    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          addr_next = reqAddr;
          len_next  = reqLen;
          cnt_next  = '0;
          if (reqLen == '0)
            state_next = DONE;
          else if (reqWr)
            state_next = WR;
          else
            state_next = RD_ISSUE;
        end
      end
      RD_ISSUE: rd_issue = 1'b1;
      RD_DRAIN: begin
        if (stage_valid[RD_LAT-1] && stage_last[RD_LAT-1])
          state_next = DONE;
      end
      WR:       wr_fire = wrValid;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    // Shared beat bookkeeping for read issues and accepted write beats
    if (rd_issue || wr_fire) begin
      addr_next = addr_reg + ADDR_W'(1);
      cnt_next  = cnt_reg + LEN_W'(1);
      if ((addr_reg == '1) && !last_beat)
        err_next = 1'b1;
      if (last_beat)
        state_next = rd_issue ? RD_DRAIN : DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[addr_reg] <= wrData;
  end

  // Stage 0 is the registered RAM read; later stages only shift on valid so data holds
  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            stage_valid[0] <= 1'b0;
            stage_last[0]  <= 1'b0;
            stage_data[0]  <= '0;
`ifdef RESP_ADDR_ECHO_EN
            stage_addr[0]  <= '0;
`endif
          end else begin
            stage_valid[0] <= rd_issue;
            stage_last[0]  <= rd_issue && last_beat;
            if (rd_issue) begin
              stage_data[0] <= mem[addr_reg];
`ifdef RESP_ADDR_ECHO_EN
              stage_addr[0] <= addr_reg;
`endif
            end
          end
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            stage_valid[gi] <= 1'b0;
            stage_last[gi]  <= 1'b0;
            stage_data[gi]  <= '0;
`ifdef RESP_ADDR_ECHO_EN
            stage_addr[gi]  <= '0;
`endif
          end else begin
            stage_valid[gi] <= stage_valid[gi-1];
            stage_last[gi]  <= stage_last[gi-1];
            if (stage_valid[gi-1]) begin
              stage_data[gi] <= stage_data[gi-1];
`ifdef RESP_ADDR_ECHO_EN
              stage_addr[gi] <= stage_addr[gi-1];
`endif
            end
          end
        end
      end
    end
  endgenerate

  assign reqReady  = (state_reg == IDLE);
  assign wrReady   = (state_reg == WR);
  assign burstDone = (state_reg == DONE);
  assign rdValid   = stage_valid[RD_LAT-1];
  assign rdData    = stage_data[RD_LAT-1];
  assign errOob    = err_reg;
`ifdef RESP_ADDR_ECHO_EN
  assign rdAddr    = stage_addr[RD_LAT-1];
`endif

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: write/read bursts, stalls, wrap, zero length, reset abort.
module tb_burst_mem_responder;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 5;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req = 1'b0;
  logic              reqWr = 1'b0;
  logic [ADDR_W-1:0] reqAddr = '0;
  logic [LEN_W-1:0]  reqLen = '0;
  logic              reqReady;
  logic [DATA_W-1:0] wrData = '0;
  logic              wrValid = 1'b0;
  logic              wrReady;
  logic [DATA_W-1:0] rdData;
  logic              rdValid;
  logic              burstDone;
  logic              errOob;
`ifdef RESP_ADDR_ECHO_EN
  logic [ADDR_W-1:0] rdAddr;
`endif

  int n_checks = 0;
  int n_pass = 0;
  logic [DATA_W-1:0] model_mem [1024];

  burst_mem_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk),
`ifdef RESP_ADDR_ECHO_EN
    .rdAddr(rdAddr),
`endif
    .rst(rst), .req(req), .reqWr(reqWr), .reqAddr(reqAddr), .reqLen(reqLen),
    .reqReady(reqReady), .wrData(wrData), .wrValid(wrValid), .wrReady(wrReady),
    .rdData(rdData), .rdValid(rdValid), .burstDone(burstDone), .errOob(errOob)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 32'(reqReady), 32'(1'b1));
    chk("rst_wr_ready", 32'(wrReady), 32'(1'b0));
    chk("rst_rd_valid", 32'(rdValid), 32'(1'b0));
    chk("rst_rd_data", 32'(rdData), 32'(8'h00));
    chk("rst_done", 32'(burstDone), 32'(1'b0));
    chk("rst_err", 32'(errOob), 32'(1'b0));
`ifdef RESP_ADDR_ECHO_EN
    chk("rst_rd_addr", 32'(rdAddr), 32'(10'h000));
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick;
    $display("reset applied");
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input int len, input logic [7:0] base,
                          input int gap_at, input int gap_len);
    int beat = 0;
    int cyc = 0;
    int gaps = gap_len;
    int dones = 0;
    logic [ADDR_W-1:0] ai;
    chk("wr_req_ready", 32'(reqReady), 32'(1'b1));
    req = 1'b1; reqWr = 1'b1; reqAddr = addr; reqLen = len[LEN_W-1:0];
    tick;
    req = 1'b0;
    while (beat < len && cyc < 100) begin
      if (beat == gap_at && gaps > 0) begin
        wrValid = 1'b0;
        gaps--;
      end else begin
        wrValid = 1'b1;
        wrData = base + beat[7:0];
      end
      if (wrValid && wrReady) begin
        ai = addr + beat[ADDR_W-1:0];
        model_mem[ai] = wrData;
        beat++;
      end
      if (burstDone) dones++;
      tick;
      cyc++;
    end
    wrValid = 1'b0;
    chk("wr_beats", 32'(beat), 32'(len));
    chk("wr_cycles", 32'(cyc), 32'(len + gap_len));
    chk("wr_early_done", 32'(dones), 32'(0));
    chk("wr_done", 32'(burstDone), 32'(1'b1));
    chk("wr_ready_off", 32'(wrReady), 32'(1'b0));
    tick;
    chk("wr_done_pulse", 32'(burstDone), 32'(1'b0));
    chk("wr_idle", 32'(reqReady), 32'(1'b1));
    $display("write burst addr=%03h len=%0d cycles=%0d", addr, len, cyc);
  endtask

  // Req accepted in cycle T; after j ticks the bench is in cycle T+j.
  task automatic do_read(input logic [ADDR_W-1:0] addr, input int len);
    logic [ADDR_W-1:0] ai;
    int i;
    bit exp_v;
    chk("rd_req_ready0", 32'(reqReady), 32'(1'b1));
    req = 1'b1; reqWr = 1'b0; reqAddr = addr; reqLen = len[LEN_W-1:0];
    tick;
    req = 1'b0;
    for (int j = 1; j <= len + RD_LAT + 2; j++) begin
      i = j - 1 - RD_LAT;
      exp_v = (i >= 0 && i < len);
      chk("rd_valid", 32'(rdValid), 32'(exp_v));
      if (exp_v) begin
        ai = addr + i[ADDR_W-1:0];
        chk("rd_data", 32'(rdData), 32'(model_mem[ai]));
`ifdef RESP_ADDR_ECHO_EN
        chk("rd_addr", 32'(rdAddr), 32'(ai));
`endif
      end
      chk("rd_done", 32'(burstDone), 32'(j == len + RD_LAT + 1));
      chk("rd_req_ready", 32'(reqReady), 32'(j == len + RD_LAT + 2));
      if (j < len + RD_LAT + 2) tick;
    end
    ai = addr + 10'(len - 1);
    chk("rd_hold", 32'(rdData), 32'(model_mem[ai]));
    $display("read burst addr=%03h len=%0d", addr, len);
  endtask

  initial begin
    int valids;
    int dones;
    #2;
    do_reset;

    // Basic write then read-back, with exact read timing
    do_write(10'h010, 4, 8'hA0, -1, 0);
    chk("err_after_wr", 32'(errOob), 32'(1'b0));
    do_read(10'h010, 4);

    // Stalled write
    do_write(10'h020, 3, 8'h50, 1, 2);
    do_read(10'h020, 3);

    // Burst ending exactly at the top address does not flag
    do_write(10'h3FE, 4, 8'hC0, -1, 0);
    chk("err_wr_wrap", 32'(errOob), 32'(1'b1));
    do_reset;
    do_read(10'h3FE, 2);
    chk("err_no_wrap", 32'(errOob), 32'(1'b0));
    do_read(10'h3FE, 4);
    chk("err_rd_wrap", 32'(errOob), 32'(1'b1));
    do_read(10'h011, 1);
    chk("err_sticky", 32'(errOob), 32'(1'b1));
    do_reset;
    chk("err_cleared", 32'(errOob), 32'(1'b0));

    // Zero-length write burst: no beats, no RAM change
    req = 1'b1; reqWr = 1'b1; reqAddr = 10'h010; reqLen = '0;
    wrValid = 1'b1; wrData = 8'hFF;
    tick;
    req = 1'b0;
    chk("len0_done", 32'(burstDone), 32'(1'b1));
    chk("len0_wr_ready", 32'(wrReady), 32'(1'b0));
    chk("len0_rd_valid", 32'(rdValid), 32'(1'b0));
    tick;
    wrValid = 1'b0;
    chk("len0_done_pulse", 32'(burstDone), 32'(1'b0));
    chk("len0_idle", 32'(reqReady), 32'(1'b1));
    $display("zero-length burst addr=010");
    do_read(10'h010, 4);

    // Request held across an active burst is served once, after DONE
    valids = 0;
    dones = 0;
    req = 1'b1; reqWr = 1'b0; reqAddr = 10'h010; reqLen = 5'd2;
    tick;
    for (int j = 1; j <= 12; j++) begin
      if (j == 7) req = 1'b0;
      if (rdValid) valids++;
      if (burstDone) dones++;
      chk("held_valid", 32'(rdValid), 32'(j == 3 || j == 4 || j == 9 || j == 10));
      chk("held_done", 32'(burstDone), 32'(j == 5 || j == 11));
      if (j == 3 || j == 9) chk("held_data0", 32'(rdData), 32'(8'hA0));
      if (j == 4 || j == 10) chk("held_data1", 32'(rdData), 32'(8'hA1));
      if (j < 12) tick;
    end
    chk("held_valid_cnt", 32'(valids), 32'(4));
    chk("held_done_cnt", 32'(dones), 32'(2));
    $display("held request served twice");

    // Reset at beat 2 of a len=8 read aborts it
    req = 1'b1; reqWr = 1'b0; reqAddr = 10'h010; reqLen = 5'd8;
    tick;
    req = 1'b0;
    for (int j = 1; j < 3 + RD_LAT; j++) tick;
    chk("abort_beat2_valid", 32'(rdValid), 32'(1'b1));
    chk("abort_beat2_data", 32'(rdData), 32'(8'hA2));
    do_reset;
    dones = 0;
    valids = 0;
    for (int j = 0; j < 12; j++) begin
      if (burstDone) dones++;
      if (rdValid) valids++;
      tick;
    end
    chk("abort_no_done", 32'(dones), 32'(0));
    chk("abort_no_beats", 32'(valids), 32'(0));
    do_read(10'h010, 4);
    do_read(10'h020, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
